sfx_scheduler: RTL
==================

SFX_SCHEDULER -- requirements
Module: sfx_scheduler

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named Clk and Reset.
REQ-002 Parameter TICK_DIV, default 6250, SHALL set the number of Clk cycles per sample tick (8 kHz at 50 MHz).
REQ-003 Parameters BASE0..BASE3, default 0, SHALL set the 14-bit ROM start word of clip n.
REQ-004 Parameters LEN0..LEN3, default 14374, SHALL set the length of clip n in samples (at least 1).
REQ-005 Clk  input  1  system clock.
REQ-006 Reset  input  1  synchronous active-high reset.
REQ-007 init_finish  input  1  codec configured; playback is enabled only while high.
REQ-008 req  input  4  one-cycle or level play request per clip; bit 3 has the highest priority.
REQ-009 stop  input  1  synchronous abort of all playback and pending requests.
REQ-010 rom_addr  output  14  sample ROM word address.
REQ-011 rom_data  input  16  ROM word, valid one Clk cycle after rom_addr.
REQ-012 ldata, rdata  output  16 each  sample to the audio interface; both carry identical values.
REQ-013 busy  output  1  a clip is playing.
REQ-014 active_id  output  2  index of the playing clip; 0 when idle.
REQ-015 done  output  1  one-cycle pulse when a clip completes naturally.

Function
REQ-016 tick_cnt SHALL count 0..TICK_DIV-1 and wrap to 0; tick is asserted for one cycle when tick_cnt==TICK_DIV-1; tick_cnt is held at 0 while init_finish is low.
REQ-017 Any cycle with req[n]=1 SHALL set pending[n]; requests arriving while init_finish is low are dropped.
REQ-018 The state machine SHALL have states IDLE, ADDR, LATCH.
- IDLE -> ADDR on tick when any pending bit is set.
- ADDR -> LATCH after one cycle.
- LATCH -> IDLE after one cycle.
REQ-019 On each tick, arbitration SHALL pick the highest set pending index p.
- Idle: p is started.
- Playing and p > active_id: p preempts the current clip.
- Playing and p == active_id: the clip restarts at offset 0.
- p < active_id: p stays pending.
- On start, pending[p] is cleared and offset is reset to 0.
REQ-020 In ADDR, rom_addr SHALL equal BASE[active_id] + offset, with 14-bit wrap-around.
REQ-021 In LATCH, ldata/rdata SHALL load rom_data, so each output update lands exactly 2 cycles after its tick.
REQ-022 While playing, each tick SHALL advance offset by 1; after the sample at offset LEN-1 is output, the clip ends.
- At the end: done pulses for 1 cycle, busy drops, and ldata/rdata are cleared to 0 at the next tick.
- Lower-priority pending requests are then arbitrated at that same tick.
REQ-023 A req bit asserted in the same cycle as the tick on which its pending bit would be consumed SHALL be treated as already pending.
REQ-024 stop SHALL have priority over req and tick; it clears pending, busy, offset, active_id and ldata/rdata in the next cycle and suppresses done.
REQ-025 init_finish falling mid-clip SHALL behave as stop.

Reset
REQ-026 Reset SHALL clear tick_cnt, pending, offset, state(=IDLE), rom_addr, ldata, rdata, busy, active_id and done to 0 on the next Clk edge.
REQ-027 Reset asserted mid-clip SHALL abort the clip with no done pulse; outputs are silent from the first cycle after the reset edge.

Configuration
REQ-028 With SFX_VOLUME_EN defined, the block SHALL add input vol[1:0]; the sample output in LATCH is rom_data arithmetically right-shifted by vol, sign preserved.
REQ-029 Without SFX_VOLUME_EN, there SHALL be no vol port and rom_data passes through unmodified.

Verification (TICK_DIV=8, BASE0=0, LEN0=3, BASE3=100, LEN3=2)
REQ-030 init_finish=1, req[0] pulse -> rom_addr 0,1,2 on successive ticks; ldata=rdata=ROM[0..2], each 2 cycles after its tick; done pulse; busy=0; output 0 at the next tick.
REQ-031 Clip 0 playing at offset 1, req[3] pulse -> next tick rom_addr=100, active_id=3; clip 0 is not resumed and no done is produced for clip 0.
REQ-032 Clip 3 playing, req[0] pulse -> clip 3 completes (done), and clip 0 starts at rom_addr 0 on that same tick.
REQ-033 Clip 0 at offset 2, req[0] again -> next rom_addr=0 (restart) with no done pulse.
REQ-034 stop, or Reset, asserted in ADDR -> the next cycle shows busy=0, ldata=0, pending=0 and no done; with init_finish low, req[1] is ignored and tick_cnt stays 0.
REQ-035 With SFX_VOLUME_EN, vol=2, ROM word 0x8000 -> ldata=0xE000; ROM word 0x7FFC -> 0x1FFF.

Source files
------------

// File: rtl/sfx_scheduler.sv
// Sound-effect clip scheduler: four prioritised ROM clips played out at a fixed sample tick.
// Optional build macro SFX_VOLUME_EN adds vol[1:0] (arithmetic right-shift of each sample).
module sfx_scheduler #(
  parameter int unsigned TICK_DIV = 6250,
  parameter logic [13:0] BASE0    = 14'd0,
  parameter logic [13:0] BASE1    = 14'd0,
  parameter logic [13:0] BASE2    = 14'd0,
  parameter logic [13:0] BASE3    = 14'd0,
  parameter int unsigned LEN0     = 14374,
  parameter int unsigned LEN1     = 14374,
  parameter int unsigned LEN2     = 14374,
  parameter int unsigned LEN3     = 14374
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        init_finish,
  input  logic [3:0]  req,
  input  logic        stop,
`ifdef SFX_VOLUME_EN
  input  logic [1:0]  vol,
`endif
  output logic [13:0] rom_addr,
  input  logic [15:0] rom_data,
  output logic [15:0] ldata,
  output logic [15:0] rdata,
  output logic        busy,
  output logic [1:0]  active_id,
  output logic        done
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, ADDR, LATCH} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]       pending_q, pending_d;
  logic [15:0]      offset_q, offset_d;
  logic [13:0]      rom_addr_q, rom_addr_d;
  logic [15:0]      ldata_q, ldata_d;
  logic             busy_q, busy_d;
  logic [1:0]       active_id_q, active_id_d;
  logic             done_q, done_d;

  logic             tick;
  logic             abort;
  logic             start;
  logic [1:0]       pick;
  logic [3:0]       pend_eff;
  logic [15:0]      next_off;
  logic [15:0]      sample;

  function automatic logic [13:0] base_of(input logic [1:0] id);
    case (id)
      2'd0:    base_of = BASE0;
      2'd1:    base_of = BASE1;
      2'd2:    base_of = BASE2;
      default: base_of = BASE3;
    endcase
  endfunction

  function automatic logic [15:0] last_off(input logic [1:0] id);
    case (id)
      2'd0:    last_off = 16'(LEN0 - 1);
      2'd1:    last_off = 16'(LEN1 - 1);
      2'd2:    last_off = 16'(LEN2 - 1);
      default: last_off = 16'(LEN3 - 1);
    endcase
  endfunction

  function automatic logic [1:0] highest(input logic [3:0] v);
    highest = 2'd0;
    for (int unsigned i = 0; i < 4; i++)
      if (v[i]) highest = 2'(i);
  endfunction

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    offset_d    = offset_q;
    rom_addr_d  = rom_addr_q;
    ldata_d     = ldata_q;
    busy_d      = busy_q;
    active_id_d = active_id_q;
    done_d      = 1'b0;
    tick        = 1'b0;
    start       = 1'b0;
    abort       = stop | ~init_finish;
    pend_eff    = pending_q | req;
    pending_d   = pend_eff;
    pick        = highest(pend_eff);
    next_off    = offset_q + 16'd1;

`ifdef SFX_VOLUME_EN
    sample = 16'($signed(rom_data) >>> vol);
`else
    sample = rom_data;
`endif

    if (!init_finish) begin
      tick_cnt_d = '0;
    end else if (tick_cnt_q == CNT_LAST) begin
      tick_cnt_d = '0;
      tick       = 1'b1;
    end else begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end

    unique case (state_q)
      ADDR:    state_d = LATCH;
      LATCH: begin
        state_d = IDLE;
        ldata_d = sample;
      end
      default: state_d = IDLE;
    endcase

    // Preempt/restart outranks natural completion; a completing clip still
    // hands the same tick to whatever lower-priority request is waiting.
    if (tick) begin
      if (busy_q && (pend_eff != '0) && (pick >= active_id_q)) begin
        start = 1'b1;
      end else if (busy_q && (offset_q == last_off(active_id_q))) begin
        done_d      = 1'b1;
        busy_d      = 1'b0;
        ldata_d     = '0;
        active_id_d = '0;
        offset_d    = '0;
        start       = |pend_eff;
      end else if (busy_q) begin
        offset_d   = next_off;
        rom_addr_d = base_of(active_id_q) + next_off[13:0];
        state_d    = ADDR;
      end else begin
        start = |pend_eff;
      end

      if (start) begin
        pending_d   = pend_eff & ~(4'b0001 << pick);
        busy_d      = 1'b1;
        active_id_d = pick;
        offset_d    = '0;
        rom_addr_d  = base_of(pick);
        state_d     = ADDR;
      end
    end

    if (abort) begin
      pending_d   = '0;
      busy_d      = 1'b0;
      offset_d    = '0;
      active_id_d = '0;
      ldata_d     = '0;
      rom_addr_d  = '0;
      done_d      = 1'b0;
      state_d     = IDLE;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      pending_q   <= '0;
      offset_q    <= '0;
      rom_addr_q  <= '0;
      ldata_q     <= '0;
      busy_q      <= 1'b0;
      active_id_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      pending_q   <= pending_d;
      offset_q    <= offset_d;
      rom_addr_q  <= rom_addr_d;
      ldata_q     <= ldata_d;
      busy_q      <= busy_d;
      active_id_q <= active_id_d;
      done_q      <= done_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign ldata     = ldata_q;
  assign rdata     = ldata_q;
  assign busy      = busy_q;
  assign active_id = active_id_q;
  assign done      = done_q;

endmodule
